// File: rtl/calc_display_driver.sv
// -----------------------------------------------------------------------------
// calc_display_driver
//
// Purpose:
//   This block sits after the calculator and drives a 4-position multiplexed
//   7-segment display from the 8-bit accumulator value.
//   - A sequential double-dabble converts the binary value into three BCD
//     digits (hundreds/tens/ones). It performs one shift per clock.
//   - A free-running refresh counter scans the positions 0..3. Position 3 is
//     the sign position.
//   - The shown digits only change when a conversion completes. A partial
//     conversion result is therefore never displayed.
//
// Optional feature macro:
//   CALC_DISP_SIGNED_EN
//     Defined:   Value is treated as two's complement. The magnitude is
//                displayed, and position 3 shows a minus sign for negative
//                values.
//     Undefined: Value is treated as unsigned 0..255. Position 3 is always
//                blank, and no sign logic is built.
//
// Parameters:
//   REFRESH_BITS  : width of the refresh counter. The scan advances each time
//                   the counter wraps, i.e. every 2**REFRESH_BITS clocks.
//   BLANK_LEADING : 1 blanks leading-zero hundreds/tens digits.
//                   0 always shows all three digits.
//
// Ports:
//   clock     in   1  single clock; all state changes on the rising edge
//   Reset     in   1  synchronous, active-high reset
//   Value     in   8  number to display
//   Segments  out  7  active-high segments, bit order {g,f,e,d,c,b,a}
//   DigitSel  out  4  one-hot active-high position select
//                     (bit0 = ones, bit3 = sign)
//   Busy      out  1  high while a conversion is in progress
// -----------------------------------------------------------------------------
module calc_display_driver #(
  parameter int REFRESH_BITS  = 16,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic       clock,
  input  logic       Reset,
  input  logic [7:0] Value,
  output logic [6:0] Segments,
  output logic [3:0] DigitSel,
  output logic       Busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_MINUS = 7'h40;
  localparam logic [6:0] SEG_ZERO  = 7'h3F;

  // Active-high segment pattern for one BCD digit.
  // Values outside 0..9 cannot occur, and they decode to blank.
  function automatic logic [6:0] seg_of_digit(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  // Returns a BCD nibble corrected for the next shift.
  // A nibble of 5 or more gets 3 added, so it carries correctly into the next
  // decade after the shift.
  function automatic logic [3:0] dd_adjust(input logic [3:0] n);
    logic [3:0] r;
    if (n >= 4'd5) begin
      r = n + 4'd3;
    end else begin
      r = n;
    end
    return r;
  endfunction

  // Performs one double-dabble step on the working vector.
  // Layout of {hund, tens, ones, bin}:
  //   [19:16] = hundreds
  //   [15:12] = tens
  //   [11:8]  = ones
  //   [7:0]   = remaining binary bits
  function automatic logic [19:0] dd_step(input logic [19:0] v);
    logic [19:0] a;
    a = {dd_adjust(v[19:16]), dd_adjust(v[15:12]), dd_adjust(v[11:8]), v[7:0]};
    return {a[18:0], 1'b0};
  endfunction

  // Converter state
  state_t      state_r;
  state_t      state_next_s;
  logic [2:0]  shift_cnt_r;
  logic [19:0] dd_r;
  logic [7:0]  last_value_r;
  logic        pending_r;
  logic        capture_s;
  logic        shift_s;
  logic        commit_s;
  logic [7:0]  mag_s;

  // Committed (displayed) digits
  logic [3:0]  shown_hund_r;
  logic [3:0]  shown_tens_r;
  logic [3:0]  shown_ones_r;
`ifdef CALC_DISP_SIGNED_EN
  logic        sign_cap_r;
  logic        shown_sign_r;
`endif

  // Scan state
  logic [REFRESH_BITS-1:0] refresh_cnt_r;
  logic                    refresh_wrap_s;
  logic [1:0]              pos_idx_r;
  logic [1:0]              pos_next_s;
  logic [6:0]              seg_next_s;
  logic [3:0]              sel_next_s;

  // Output registers
  logic [6:0]  segments_r;
  logic [3:0]  digit_sel_r;
  logic        busy_r;

  // Magnitude loaded into the converter.
  // In signed mode, 8'h80 negates to itself, which reads as 128.
  always_comb begin
    mag_s = Value;
`ifdef CALC_DISP_SIGNED_EN
    if (Value[7]) begin
      mag_s = 8'd0 - Value;
    end else begin
      mag_s = Value;
    end
`endif
  end

  // Converter state register
  always_ff @(posedge clock) begin
    if (Reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Converter next-state and datapath strobes
  always_comb begin
    state_next_s = state_r;
    capture_s    = 1'b0;
    shift_s      = 1'b0;
    commit_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // A conversion starts after reset, or whenever Value differs from
        // the last value captured.
        if (pending_r || (Value != last_value_r)) begin
          capture_s    = 1'b1;
          state_next_s = ST_SHIFT;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        shift_s = 1'b1;
        if (shift_cnt_r == 3'd7) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_SHIFT;
        end
      end
      ST_DONE: begin
        commit_s     = 1'b1;
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Converter datapath: capture, shift and commit to the shown digits
  always_ff @(posedge clock) begin
    if (Reset) begin
      shift_cnt_r  <= 3'd0;
      dd_r         <= 20'h00000;
      last_value_r <= 8'h00;
      pending_r    <= 1'b1;
      shown_hund_r <= 4'd0;
      shown_tens_r <= 4'd0;
      shown_ones_r <= 4'd0;
`ifdef CALC_DISP_SIGNED_EN
      sign_cap_r   <= 1'b0;
      shown_sign_r <= 1'b0;
`endif
    end else begin
      if (capture_s) begin
        dd_r         <= {12'h000, mag_s};
        last_value_r <= Value;
        pending_r    <= 1'b0;
        shift_cnt_r  <= 3'd0;
`ifdef CALC_DISP_SIGNED_EN
        sign_cap_r   <= Value[7];
`endif
      end else if (shift_s) begin
        dd_r        <= dd_step(dd_r);
        shift_cnt_r <= shift_cnt_r + 3'd1;
      end
      if (commit_s) begin
        shown_hund_r <= dd_r[19:16];
        shown_tens_r <= dd_r[15:12];
        shown_ones_r <= dd_r[11:8];
`ifdef CALC_DISP_SIGNED_EN
        shown_sign_r <= sign_cap_r;
`endif
      end
    end
  end

  // Scan position and segment pattern that take effect on the next edge
  always_comb begin
    refresh_wrap_s = (refresh_cnt_r == {REFRESH_BITS{1'b1}});
    if (refresh_wrap_s) begin
      pos_next_s = pos_idx_r + 2'd1;
    end else begin
      pos_next_s = pos_idx_r;
    end
    case (pos_next_s)
      2'd0: begin
        sel_next_s = 4'b0001;
        seg_next_s = seg_of_digit(shown_ones_r);
      end
      2'd1: begin
        sel_next_s = 4'b0010;
        if (BLANK_LEADING && (shown_hund_r == 4'd0) && (shown_tens_r == 4'd0)) begin
          seg_next_s = SEG_BLANK;
        end else begin
          seg_next_s = seg_of_digit(shown_tens_r);
        end
      end
      2'd2: begin
        sel_next_s = 4'b0100;
        if (BLANK_LEADING && (shown_hund_r == 4'd0)) begin
          seg_next_s = SEG_BLANK;
        end else begin
          seg_next_s = seg_of_digit(shown_hund_r);
        end
      end
      2'd3: begin
        sel_next_s = 4'b1000;
`ifdef CALC_DISP_SIGNED_EN
        if (shown_sign_r) begin
          seg_next_s = SEG_MINUS;
        end else begin
          seg_next_s = SEG_BLANK;
        end
`else
        seg_next_s = SEG_BLANK;
`endif
      end
      default: begin
        sel_next_s = 4'b0001;
        seg_next_s = SEG_BLANK;
      end
    endcase
  end

  // Refresh counter, scan index and registered display outputs.
  // Segments and DigitSel load on the same edge, so they never disagree.
  always_ff @(posedge clock) begin
    if (Reset) begin
      refresh_cnt_r <= {REFRESH_BITS{1'b0}};
      pos_idx_r     <= 2'd0;
      segments_r    <= SEG_ZERO;
      digit_sel_r   <= 4'b0001;
      busy_r        <= 1'b0;
    end else begin
      refresh_cnt_r <= refresh_cnt_r + {{(REFRESH_BITS-1){1'b0}}, 1'b1};
      pos_idx_r     <= pos_next_s;
      segments_r    <= seg_next_s;
      digit_sel_r   <= sel_next_s;
      busy_r        <= (state_next_s != ST_IDLE);
    end
  end

  assign Segments = segments_r;
  assign DigitSel = digit_sel_r;
  assign Busy     = busy_r;

endmodule
